// File: rtl/teller_call_unit_pkg.sv
// teller_call_unit_pkg: shared state encoding, queue limit, BCD widths and BCD helpers
package teller_call_unit_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, CALL = 2'd2, SERVE = 2'd3} state_t;
    localparam logic [2:0] QUEUE_MAX = 3'd7;
    localparam int DIGIT_W = 4;
    localparam int BCD_W = 2 * DIGIT_W;
    function automatic logic [BCD_W-1:0] bcd2_inc(input logic [BCD_W-1:0] v, input logic sat);
        if (v == 8'h99) return sat ? v : '0;
        return (v[DIGIT_W-1:0] == 4'd9) ? {v[BCD_W-1:DIGIT_W] + 4'd1, 4'd0}
                                        : {v[BCD_W-1:DIGIT_W], v[DIGIT_W-1:0] + 4'd1};
    endfunction
    function automatic logic [BCD_W-1:0] to_bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction
endpackage

// File: rtl/teller_call_unit_bcd2_counter.sv
// bcd2_counter: 2-digit BCD up-counter, wraps 99->00 or holds at 99 when SATURATE
//   clk, reset : clock, asynchronous active-high reset
//   inc_i      : advance by one
//   clr_i      : synchronous clear, wins over inc_i
//   q_o        : {tens, units}
module bcd2_counter
    import teller_call_unit_pkg::*;
#(
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [BCD_W-1:0] q_o
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q_o <= '0;
        else if (clr_i) q_o <= '0;
        else if (inc_i) q_o <= bcd2_inc(q_o, SATURATE);
    end
endmodule

// File: rtl/teller_call_unit.sv
// teller_call_unit: teller-side queue consumer (dequeue pulse, ticket/serving numbers, call lamp, service timer)
//   clk, reset  : 100 Hz clock, asynchronous active-high reset
//   in_pulse    : customer-entry pulse (queue's in)
//   next_btn    : teller call-next pulse
//   done_btn    : teller service-done / no-show pulse
//   pcount      : queue occupancy 0..7
//   out_pulse   : one-cycle dequeue request to the queue
//   ticket_bcd  : last ticket issued, BCD
//   serving_bcd : ticket being served, BCD
//   call_lamp   : high during CALL
//   busy        : high during CALL or SERVE
//   svc_bcd     : elapsed service seconds, BCD, saturating at 99
//   overtime    : SERVE with svc_bcd >= MAX_SVC_SECS
module teller_call_unit
    import teller_call_unit_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int CALL_SECS     = 3,
    parameter int MAX_SVC_SECS  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_pulse,
    input  logic             next_btn,
    input  logic             done_btn,
    input  logic [2:0]       pcount,
    output logic             out_pulse,
    output logic [BCD_W-1:0] ticket_bcd,
    output logic [BCD_W-1:0] serving_bcd,
    output logic             call_lamp,
    output logic             busy,
    output logic [BCD_W-1:0] svc_bcd,
    output logic             overtime
);
    localparam int CALL_CYC = CALL_SECS * TICKS_PER_SEC;
    localparam int CW = $clog2(CALL_CYC + 1);
    localparam int PW = $clog2(TICKS_PER_SEC + 1);
    localparam logic [CW-1:0] CALL_LAST = CW'(CALL_CYC - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [BCD_W-1:0] MAX_BCD = to_bcd2(MAX_SVC_SECS);

    state_t        state_q;
    logic          out_pulse_q;
    logic [CW-1:0] call_cnt_q;
    logic [PW-1:0] presc_q;
    logic          nonempty, pop, wrap, svc_inc, ticket_inc;

    // A pop issued together with a push would be swallowed by the queue, so pop waits for a quiet in_pulse.
    always_comb begin
        nonempty   = pcount != 3'd0;
        pop        = !in_pulse && nonempty && ((state_q == IDLE && next_btn) || state_q == PEND);
        wrap       = state_q == SERVE && presc_q == PRE_LAST;
        svc_inc    = wrap && !done_btn;
        ticket_inc = in_pulse && pcount != QUEUE_MAX;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            out_pulse_q <= 1'b0;
            call_cnt_q  <= '0;
            presc_q     <= '0;
        end else begin
            out_pulse_q <= pop;
            unique case (state_q)
                IDLE:  if (next_btn && nonempty) state_q <= in_pulse ? PEND : CALL;
                PEND:  if (!in_pulse) state_q <= nonempty ? CALL : IDLE;
                CALL: begin
                    call_cnt_q <= call_cnt_q + 1'b1;
                    if (done_btn) state_q <= IDLE;
                    else if (call_cnt_q == CALL_LAST) state_q <= SERVE;
                end
                SERVE: begin
                    presc_q <= wrap ? '0 : presc_q + 1'b1;
                    if (done_btn) state_q <= IDLE;
                end
            endcase
            if (pop) begin
                call_cnt_q <= '0;
                presc_q    <= '0;
            end
        end
    end

    assign out_pulse = out_pulse_q;
    assign call_lamp = state_q == CALL;
    assign busy      = state_q == CALL || state_q == SERVE;
    assign overtime  = state_q == SERVE && svc_bcd >= MAX_BCD;

    bcd2_counter #(.SATURATE(1'b0)) u_ticket (
        .clk(clk), .reset(reset), .inc_i(ticket_inc), .clr_i(1'b0), .q_o(ticket_bcd)
    );
    bcd2_counter #(.SATURATE(1'b0)) u_serving (
        .clk(clk), .reset(reset), .inc_i(pop), .clr_i(1'b0), .q_o(serving_bcd)
    );
    bcd2_counter #(.SATURATE(1'b1)) u_svc (
        .clk(clk), .reset(reset), .inc_i(svc_inc), .clr_i(pop), .q_o(svc_bcd)
    );
endmodule

// File: tb/tb_teller_call_unit.sv
// tb_teller_call_unit: table vectors, corner sequences and random stimulus against a queue/teller model
module tb_teller_call_unit;
    localparam int TPS = 100, CS = 3, MS = 10;
    localparam int M_IDLE = 0, M_PEND = 1, M_CALL = 2, M_SERVE = 3;

    logic clk = 1'b0, reset = 1'b1, in_pulse = 1'b0, next_btn = 1'b0, done_btn = 1'b0;
    logic [2:0] pcount = 3'd0;
    logic out_pulse, call_lamp, busy, overtime;
    logic [7:0] ticket_bcd, serving_bcd, svc_bcd;

    teller_call_unit #(.TICKS_PER_SEC(TPS), .CALL_SECS(CS), .MAX_SVC_SECS(MS)) dut (
        .clk(clk), .reset(reset), .in_pulse(in_pulse), .next_btn(next_btn), .done_btn(done_btn),
        .pcount(pcount), .out_pulse(out_pulse), .ticket_bcd(ticket_bcd), .serving_bcd(serving_bcd),
        .call_lamp(call_lamp), .busy(busy), .svc_bcd(svc_bcd), .overtime(overtime)
    );

    always #5 clk = ~clk;

    int vecs = 0, errs = 0;
    int m_st, m_tick, m_serv, m_svc, m_call, m_serve_cyc, q_pc;
    bit m_out;

    typedef struct {
        bit i, n, d, out;
        logic [7:0] tk, sv;
        bit lamp, busy;
    } vec_t;
    vec_t tbl[11];

    function automatic logic [7:0] bcd(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_tick = 0; m_serv = 0; m_svc = 0; m_call = 0; m_serve_cyc = 0;
        m_out = 0; q_pc = 0; pcount = 3'd0;
    endtask

    task automatic model_pop();
        m_out = 1; m_serv = (m_serv + 1) % 100; m_st = M_CALL;
        m_call = 0; m_serve_cyc = 0; m_svc = 0;
    endtask

    // One clock: drive inputs, advance the queue and the teller model, leave outputs settled.
    task automatic tick(input bit i, input bit n, input bit d);
        bit pre_out;
        int pc;
        in_pulse = i; next_btn = n; done_btn = d;
        pre_out = out_pulse;
        pc = q_pc;
        @(posedge clk); #1;
        in_pulse = 0; next_btn = 0; done_btn = 0;
        if (i) begin if (q_pc < 7) q_pc++; end
        else if (pre_out && q_pc > 0) q_pc--;
        pcount = 3'(q_pc);
        m_out = 0;
        if (i && pc != 7) m_tick = (m_tick + 1) % 100;
        case (m_st)
            M_IDLE:  if (n && pc != 0) begin if (i) m_st = M_PEND; else model_pop(); end
            M_PEND:  if (!i) begin if (pc != 0) model_pop(); else m_st = M_IDLE; end
            M_CALL: begin
                m_call++;
                if (d) m_st = M_IDLE;
                else if (m_call == CS * TPS) m_st = M_SERVE;
            end
            default: begin
                if (d) m_st = M_IDLE;
                else begin
                    m_serve_cyc++;
                    m_svc = (m_serve_cyc / TPS > 99) ? 99 : m_serve_cyc / TPS;
                end
            end
        endcase
    endtask

    task automatic check_model(string name);
        logic [27:0] act, exp;
        act = {out_pulse, ticket_bcd, serving_bcd, call_lamp, busy, svc_bcd, overtime};
        exp = {m_out, bcd(m_tick), bcd(m_serv), m_st == M_CALL, m_st == M_CALL || m_st == M_SERVE,
               bcd(m_svc), m_st == M_SERVE && m_svc >= MS};
        check(name, {4'd0, act}, {4'd0, exp});
    endtask

    task automatic do_reset();
        reset = 1; in_pulse = 0; next_btn = 0; done_btn = 0;
        model_reset();
        @(posedge clk); #1;
        reset = 0;
    endtask

    initial begin
        int n;
        tbl[0]  = '{1, 0, 0, 0, 8'h01, 8'h00, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 8'h02, 8'h00, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 8'h03, 8'h00, 0, 0};
        tbl[3]  = '{0, 1, 0, 1, 8'h03, 8'h01, 1, 1};
        tbl[4]  = '{0, 0, 0, 0, 8'h03, 8'h01, 1, 1};
        tbl[5]  = '{0, 0, 1, 0, 8'h03, 8'h01, 0, 0};
        tbl[6]  = '{1, 1, 0, 0, 8'h04, 8'h01, 0, 0};
        tbl[7]  = '{0, 0, 0, 1, 8'h04, 8'h02, 1, 1};
        tbl[8]  = '{0, 1, 0, 0, 8'h04, 8'h02, 1, 1};
        tbl[9]  = '{0, 0, 1, 0, 8'h04, 8'h02, 0, 0};
        tbl[10] = '{0, 0, 1, 0, 8'h04, 8'h02, 0, 0};

        do_reset();
        check("reset", {4'd0, out_pulse, ticket_bcd, serving_bcd, call_lamp, busy, svc_bcd, overtime}, 32'd0);

        for (int k = 0; k < 11; k++) begin
            tick(tbl[k].i, tbl[k].n, tbl[k].d);
            check($sformatf("vec%0d", k), {13'd0, out_pulse, ticket_bcd, serving_bcd, call_lamp, busy},
                  {13'd0, tbl[k].out, tbl[k].tk, tbl[k].sv, tbl[k].lamp, tbl[k].busy});
        end
        check("queue_after_pend", {29'd0, pcount}, 32'd2);

        // Lamp width, overtime threshold, done holding svc.
        tick(0, 1, 0);
        check("call_pulse", {31'd0, out_pulse}, 32'd1);
        n = 0;
        while (call_lamp === 1'b1 && n < 1000) begin n++; tick(0, 0, 0); end
        check("lamp_cycles", n, 32'd300);
        check("serve_busy", {30'd0, busy, call_lamp}, 32'd2);
        repeat (999) tick(0, 0, 0);
        check("svc_9", {23'd0, svc_bcd, overtime}, {23'd0, 8'h09, 1'b0});
        tick(0, 0, 0);
        check("svc_10", {23'd0, svc_bcd, overtime}, {23'd0, 8'h10, 1'b1});
        repeat (100) tick(0, 0, 0);
        check("svc_11", {23'd0, svc_bcd, overtime}, {23'd0, 8'h11, 1'b1});
        tick(0, 0, 1);
        check("done_hold", {22'd0, busy, overtime, svc_bcd}, {22'd0, 2'b00, 8'h11});

        // Empty queue and full queue.
        do_reset();
        tick(0, 1, 0);
        check("empty_next", {30'd0, out_pulse, busy}, 32'd0);
        tick(0, 0, 0);
        check("empty_idle", {30'd0, out_pulse, busy}, 32'd0);
        repeat (7) tick(1, 0, 0);
        check("fill7", {24'd0, ticket_bcd}, 32'h07);
        tick(1, 0, 0);
        check("full_ticket", {24'd0, ticket_bcd}, 32'h07);

        // Wrap of ticket/serving, svc saturation.
        do_reset();
        for (int k = 0; k < 99; k++) begin
            tick(1, 0, 0); tick(0, 1, 0); tick(0, 0, 1);
        end
        check("pre99", {16'd0, ticket_bcd, serving_bcd}, 32'h9999);
        tick(1, 0, 0);
        tick(0, 1, 0);
        check("wrap00", {15'd0, out_pulse, ticket_bcd, serving_bcd}, 32'h10000);
        repeat (CS * TPS + 120 * TPS) tick(0, 0, 0);
        check("svc_sat", {23'd0, svc_bcd, overtime}, {23'd0, 8'h99, 1'b1});
        check_model("sat_model");

        // Asynchronous reset in the middle of CALL.
        do_reset();
        tick(1, 0, 0); tick(0, 1, 0);
        repeat (50) tick(0, 0, 0);
        check("mid_call", {31'd0, call_lamp}, 32'd1);
        #2 reset = 1;
        #1 check("async_rst", {4'd0, out_pulse, ticket_bcd, serving_bcd, call_lamp, busy, svc_bcd, overtime}, 32'd0);
        model_reset();
        @(posedge clk); #1;
        reset = 0;
        tick(1, 0, 0);
        check("post_rst_ticket", {24'd0, ticket_bcd}, 32'h01);

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 6000; k++) begin
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0);
            check_model($sformatf("rand%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
